// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial adder controller: drives one external 4-bit CLA slice per clock,
// LSB nibble first, chaining the carry through an internal register.
//
// state | meaning
// IDLE  | waiting for start; CLA slice inputs held at 0
// RUN   | one nibble per cycle, nib_idx selects the slice
// DONE  | single-cycle result pulse; may accept a new start
module cla_nibble_sequencer #(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic [3:0]       cla_A,
    output logic [3:0]       cla_B,
    output logic             cla_Cin,
    input  logic [3:0]       cla_S,
    input  logic             cla_Cout
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [IW-1:0]    nib_idx;
    logic [WIDTH-1:0] a_reg, b_reg, s_reg;
    logic             carry_reg, cout_reg, v_reg;
    logic             accept, last_nib;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_nib = (nib_idx == IW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        cla_A      = 4'd0;
        cla_B      = 4'd0;
        cla_Cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                cla_Cin = carry_reg;
                for (int i = 0; i < NIB; i++) begin
                    if (nib_idx == IW'(i)) begin
                        cla_A = a_reg[i*4 +: 4];
                        cla_B = b_reg[i*4 +: 4];
                    end
                end
                if (last_nib) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, per-nibble sum write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_idx   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            v_reg     <= 1'b0;
        end else if (accept) begin
            nib_idx   <= '0;
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            v_reg     <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIB; i++) begin
                if (nib_idx == IW'(i)) s_reg[i*4 +: 4] <= cla_S;
            end
            carry_reg <= cla_Cout;
            if (last_nib) begin
                nib_idx  <= '0;
                cout_reg <= cla_Cout;
                v_reg    <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (cla_S[3] != a_reg[WIDTH-1]);
            end else begin
                nib_idx <= nib_idx + IW'(1);
            end
        end
    end

    assign S    = s_reg;
    assign Cout = cout_reg;
    assign V    = v_reg;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: behavioural 4-bit CLA slice plus an
// arithmetic reference for {Cout,S}, V, latency and per-nibble carry-in.
module tb_cla_nibble_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done;
    logic [15:0] s;
    logic        cout, v;
    logic [3:0]  cla_a, cla_b, cla_s;
    logic        cla_cin, cla_cout;

    int n_checks = 0;
    int n_fail   = 0;

    cla_nibble_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .busy     (busy),
        .done     (done),
        .S        (s),
        .Cout     (cout),
        .V        (v),
        .cla_A    (cla_a),
        .cla_B    (cla_b),
        .cla_Cin  (cla_cin),
        .cla_S    (cla_s),
        .cla_Cout (cla_cout)
    );

    // External CLA slice
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        cin   = tc;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    // Starts at the negedge after the accept edge; sample 0 is the first RUN cycle.
    task automatic wait_done(output int lat, output int bcnt, output logic [3:0] cins);
        lat  = -1;
        bcnt = 0;
        cins = 4'd0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (busy && done) begin
                n_fail++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
            end
            if (busy) begin
                if (bcnt < 4) cins[bcnt] = cla_cin;
                bcnt++;
            end
            if (done) lat = i;
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 20 cycles, required done at cycle 4");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'hA5A5;
        b = 16'h5A5A;
        cin = 1'b1;
        #3;
        n_checks++;
        if ({s, cout, v, busy, done, cla_a, cla_b, cla_cin} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got S=%h Cout=%b V=%b busy=%b done=%b claA=%h claB=%h claCin=%b, required all 0",
                     s, cout, v, busy, done, cla_a, cla_b, cla_cin);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, s} !== 18'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b S=%h, required 0 0 0000", busy, done, s);
        end
    endtask

    task automatic test_arith(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                              input string name);
        int          lat, bcnt;
        logic [3:0]  cins, exp_cins;
        logic [16:0] sum;
        logic        exp_v;
        logic [16:0] part;
        sum   = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
        exp_v = (ta[15] == tb_[15]) && (sum[15] != ta[15]);
        for (int k = 0; k < 4; k++) begin
            part = {1'b0, ta & 16'((1 << (4 * k)) - 1)} + {1'b0, tb_ & 16'((1 << (4 * k)) - 1)} + {16'd0, tc};
            exp_cins[k] = (k == 0) ? tc : part[4 * k];
        end
        start_op(ta, tb_, tc);
        wait_done(lat, bcnt, cins);
        n_checks++;
        if (lat != 4 || bcnt != 4) begin
            n_fail++;
            $display("FAIL %s latency: done at cycle %0d busy cycles %0d, required 4 and 4", name, lat, bcnt);
        end
        n_checks++;
        if ({cout, s} !== sum) begin
            n_fail++;
            $display("FAIL %s sum: got Cout=%b S=%h, required Cout=%b S=%h", name, cout, s, sum[16], sum[15:0]);
        end
        n_checks++;
        if (v !== exp_v) begin
            n_fail++;
            $display("FAIL %s overflow: got V=%b, required %b", name, v, exp_v);
        end
        n_checks++;
        if (cins !== exp_cins) begin
            n_fail++;
            $display("FAIL %s nibble_carry: got cla_Cin per nibble=%b, required %b", name, cins, exp_cins);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, s} !== sum || v !== exp_v) begin
            n_fail++;
            $display("FAIL %s hold: done=%b busy=%b Cout=%b S=%h V=%b, required 0 0 %b %h %b",
                     name, done, busy, cout, s, v, sum[16], sum[15:0], exp_v);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        start_op(16'h1234, 16'h0F0F, 1'b1);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (done) lat = i;
            if (i == 1) begin
                start = 1'b1;
                a     = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL ignore_start latency: done at cycle %0d, required 4", lat);
        end
        n_checks++;
        if (s !== 16'h2144 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start result: got S=%h Cout=%b, required 2144 0", s, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int d1, d2, ndone;
        d1 = -1;
        d2 = -1;
        ndone = 0;
        start_op(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 30 && d2 < 0; i++) begin
            if (i > 0) @(negedge clk);
            start = 1'b0;
            if (busy && done) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_overlap: busy and done high together at cycle %0d", i);
            end
            if (done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = i;
                    n_checks++;
                    if (s !== 16'h3333 || cout !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_first: got S=%h Cout=%b, required 3333 0", s, cout);
                    end
                    start = 1'b1;
                    a     = 16'h0007;
                    b     = 16'h0006;
                    cin   = 1'b1;
                end else begin
                    d2 = i;
                end
            end
            if (i == d1 + 1 && d1 >= 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy: busy=%b after DONE accept, required 1", busy);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (ndone != 2 || d2 - d1 != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: done pulses=%0d spacing=%0d, required 2 and 5", ndone, d2 - d1);
        end
        n_checks++;
        if (s !== 16'h000E || cout !== 1'b0 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got S=%h Cout=%b V=%b, required 000e 0 0", s, cout, v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(16'hABCD, 16'h1357, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s, cout, v, busy, done, cla_a, cla_b, cla_cin} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got S=%h Cout=%b V=%b busy=%b done=%b claA=%h claB=%h claCin=%b, required all 0",
                     s, cout, v, busy, done, cla_a, cla_b, cla_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: busy/done seen %0d cycles after reset, required 0", seen);
        end
        test_arith(16'hABCD, 16'h1357, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            test_arith(16'($urandom), 16'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_arith(16'h0000, 16'h0000, 1'b0, "zero");
        test_arith(16'hFFFF, 16'h0001, 1'b0, "ripple");
        test_arith(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
        test_arith(16'h8000, 16'h8000, 1'b1, "neg_ovf");
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands by sequencing one shared 4-bit carry-lookahead adder slice, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles through an internal carry register.
- The 4-bit CLA sits outside this block; it is connected through the cla_* ports and is purely combinational.
- Sits between a requester (start/done handshake) and the adder datapath.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when the block can accept (IDLE or DONE)
- A  input  WIDTH  operand A, sampled on the accepting edge
- B  input  WIDTH  operand B, sampled on the accepting edge
- Cin  input  1  carry-in, sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; S, Cout and V are valid
- S  output  WIDTH  sum register
- Cout  output  1  final carry-out
- V  output  1  signed overflow flag
- cla_A  output  4  nibble of A driven to the CLA slice
- cla_B  output  4  nibble of B driven to the CLA slice
- cla_Cin  output  1  carry driven to the CLA slice
- cla_S  input  4  CLA slice sum
- cla_Cout  input  1  CLA slice carry-out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; nib index=0; A/B/carry registers=0.
  - Outputs at reset: S=0, Cout=0, V=0, busy=0, done=0, cla_A=0, cla_B=0, cla_Cin=0.
- States and transitions:
  - IDLE: wait for start.
  - RUN: one nibble per cycle.
  - DONE: single cycle.
  - IDLE -> RUN on start.
  - RUN -> DONE after nib index NIB-1 is processed.
  - DONE -> RUN if start, else DONE -> IDLE.
- Accept (IDLE or DONE, start=1): latch A, B and Cin into the carry register; nib index=0; clear S to 0.
  - Cout and V are cleared on accept.
- RUN, nib index k:
  - cla_A = A_reg[4k+3:4k]; cla_B = B_reg[4k+3:4k]; cla_Cin = carry_reg (combinational from registers).
  - At the clock edge: S[4k+3:4k] <= cla_S; carry_reg <= cla_Cout; k <= k+1.
- Last nibble (k=NIB-1), at the edge:
  - Cout <= cla_Cout.
  - V <= (A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (cla_S[3] != A_reg[WIDTH-1]).
  - state <= DONE.
- Outside RUN: cla_A, cla_B and cla_Cin are driven to 0.
- Latency: with start accepted at edge 0, nibbles are captured at edges 1..NIB. done is high in the cycle following edge NIB. Total is NIB+1 cycles from accept to done.
- busy=1 exactly in RUN. done=1 exactly in DONE. busy and done are never high together.
- start while in RUN is ignored: no re-latch, and the operation completes unaffected.
- Back-to-back: start high during DONE is accepted. done still pulses for that cycle, and busy rises the next cycle.
- S, Cout and V hold their values from DONE until the next accept.
- Reset mid-operation aborts immediately to the reset values above. No done pulse is produced.
- Arithmetic: {Cout,S} = A + B + Cin, computed modulo 2^(WIDTH+1).

Test Plan:
- All test cases use WIDTH=16.
- A=0x0000, B=0x0000, Cin=0, single start -> busy high for 4 cycles; done pulses once 5 cycles after accept; S=0x0000, Cout=0, V=0.
- A=0xFFFF, B=0x0001, Cin=0 (full carry ripple through every nibble) -> S=0x0000, Cout=1, V=0. Also check that cla_Cin=1 on nibbles 1..3.
- A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, V=1.
- A=0x8000, B=0x8000, Cin=1 -> S=0x0001, Cout=1, V=1.
- A=0x1234, B=0x0F0F, Cin=1; pulse start again on cycle 2 of RUN with A=0xFFFF -> second start ignored; S=0x2144, Cout=0.
- Start accepted on the DONE cycle: second operation A=0x0007, B=0x0006, Cin=1 -> done pulses twice, 5 cycles apart; second result S=0x000E.
- Assert rst_n low during RUN nibble 2 -> all outputs return to 0 immediately and no done pulse follows. A fresh start after release computes correctly.
